// File: rtl/uart_tx_pkg.sv
// Shared definitions for the configuration-link UART: parameter ordering,
// bit timing common to transmitter and receiver, and transmitter states.
package uart_tx_pkg;

    // Order of the configuration parameters inside a frame array.
    typedef enum logic [2:0] {
        CONF_REF_GEN     = 3'd0,
        CONF_PHASE_SHIFT = 3'd1,
        CONF_OCD_LVL     = 3'd2,
        CONF_INTER_FREQ  = 3'd3,
        CONF_INTER_DUTY  = 3'd4
    } conf_par_t;

    // Highest parameter index; frames are sent from this index down to 0.
    localparam int CONF_PAR_4 = int'(CONF_INTER_DUTY);
    localparam int PAR_IDX_W  = 3;

    // Bit timing shared with the receiver: one bit lasts UART_BIT_CNT_MAX+1 clocks.
    localparam int UART_BIT_CNT_MAX      = 32'sd104;
    localparam int UART_DATA_BIT_CNT_MAX = 32'sd7;
    localparam int UART_CONF_PAR_MAX     = 32'sd255;

    // Transmitter states, kept as plain constants for compatibility with older code.
    localparam logic [1:0] TX_IDLE  = 2'd0;
    localparam logic [1:0] TX_START = 2'd1;
    localparam logic [1:0] TX_DATA  = 2'd2;
    localparam logic [1:0] TX_STOP  = 2'd3;

    // Number of bits needed to hold a non-negative value (at least 1).
    function automatic int width(input int value);
        int w;
        w = 32'sd1;
        for (int i = 32'sd1; i < 32'sd31; i++) begin
            if ((value >> i) != 32'sd0) begin
                w = i + 32'sd1;
            end else begin
                w = w;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/uart_tx_baud_timer.sv
// Reloadable bit-period down-counter. `load` restarts the period; `tick`
// is high while the count sits at zero, i.e. in the last cycle of a period.
module baud_timer
    import uart_tx_pkg::*;
#(
    parameter int CNT_MAX = UART_BIT_CNT_MAX
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic tick
);

    localparam int CW = width(CNT_MAX);

    logic [CW-1:0] count_r;

    // Reload on request, otherwise count down to zero and hold there.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {CW{1'b0}};
        end else if (load) begin
            count_r <= CW'(CNT_MAX);
        end else if (count_r != {CW{1'b0}}) begin
            count_r <= count_r - CW'(1'b1);
        end else begin
            count_r <= count_r;
        end
    end

    assign tick = (count_r == {CW{1'b0}});

endmodule

// File: rtl/uart_tx.sv
// 8N1 transmitter for the configuration frame. On `start` the parameter
// array is captured, then sent as characters par[4] .. par[0], LSB first,
// with no idle gap between characters. All outputs are registered.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int BIT_CNT_MAX      = UART_BIT_CNT_MAX,
    parameter int DATA_BIT_CNT_MAX = UART_DATA_BIT_CNT_MAX,
    parameter int CONF_PAR_MAX     = UART_CONF_PAR_MAX
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [width(CONF_PAR_MAX)-1:0]  par [0:CONF_PAR_4],
    output logic                            uart_data,
    output logic                            busy,
    output logic                            done
);

    localparam int DW = width(CONF_PAR_MAX);
    localparam int BW = width(DATA_BIT_CNT_MAX);

    logic [1:0]           state_r;
    logic [PAR_IDX_W-1:0] par_idx_r;
    logic [BW-1:0]        bit_idx_r;
    logic [DW-1:0]        snap_r [0:CONF_PAR_4];
    logic                 uart_data_r;
    logic                 busy_r;
    logic                 done_r;

    logic                 tick_s;
    logic                 load_s;
    logic [BW-1:0]        bit_nxt_s;
    logic [DW-1:0]        cur_byte_s;

    baud_timer #(
        .CNT_MAX (BIT_CNT_MAX)
    ) u_baud_timer (
        .clk  (clk),
        .rst  (rst),
        .load (load_s),
        .tick (tick_s)
    );

    // Restart the bit period on frame acceptance and at every bit boundary.
    always_comb begin
        load_s     = 1'b0;
        bit_nxt_s  = bit_idx_r + BW'(1'b1);
        cur_byte_s = snap_r[par_idx_r];
        case (state_r)
            TX_IDLE: begin
                if (start) begin
                    load_s = 1'b1;
                end else begin
                    load_s = 1'b0;
                end
            end
            TX_START, TX_DATA, TX_STOP: begin
                if (tick_s) begin
                    load_s = 1'b1;
                end else begin
                    load_s = 1'b0;
                end
            end
            default: begin
                load_s = 1'b0;
            end
        endcase
    end

    // Frame sequencer: snapshot, start bit, data bits, stop bit, next character.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= TX_IDLE;
            par_idx_r   <= {PAR_IDX_W{1'b0}};
            bit_idx_r   <= {BW{1'b0}};
            snap_r      <= '{default: {DW{1'b0}}};
            uart_data_r <= 1'b1;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                TX_IDLE: begin
                    if (start) begin
                        // Capture the whole array so mid-frame updates cannot tear it.
                        snap_r      <= par;
                        par_idx_r   <= PAR_IDX_W'(CONF_PAR_4);
                        state_r     <= TX_START;
                        busy_r      <= 1'b1;
                        uart_data_r <= 1'b0;
                    end else begin
                        uart_data_r <= 1'b1;
                        busy_r      <= 1'b0;
                    end
                end
                TX_START: begin
                    if (tick_s) begin
                        state_r     <= TX_DATA;
                        bit_idx_r   <= {BW{1'b0}};
                        uart_data_r <= cur_byte_s[{BW{1'b0}}];
                    end else begin
                        uart_data_r <= 1'b0;
                    end
                end
                TX_DATA: begin
                    if (tick_s) begin
                        if (bit_idx_r == BW'(DATA_BIT_CNT_MAX)) begin
                            state_r     <= TX_STOP;
                            uart_data_r <= 1'b1;
                        end else begin
                            bit_idx_r   <= bit_nxt_s;
                            uart_data_r <= cur_byte_s[bit_nxt_s];
                        end
                    end else begin
                        uart_data_r <= uart_data_r;
                    end
                end
                TX_STOP: begin
                    if (tick_s) begin
                        if (par_idx_r != {PAR_IDX_W{1'b0}}) begin
                            // Next character follows immediately, no idle gap.
                            par_idx_r   <= par_idx_r - PAR_IDX_W'(1'b1);
                            state_r     <= TX_START;
                            uart_data_r <= 1'b0;
                        end else begin
                            state_r     <= TX_IDLE;
                            busy_r      <= 1'b0;
                            done_r      <= 1'b1;
                            uart_data_r <= 1'b1;
                        end
                    end else begin
                        uart_data_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= TX_IDLE;
                    busy_r      <= 1'b0;
                    uart_data_r <= 1'b1;
                end
            endcase
        end
    end

    assign uart_data = uart_data_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus pushes expected characters (value and
// start cycle) and done cycles; a serial monitor decodes the line at bit
// centres and a done monitor checks the pulse timing. A small receiver model
// fills sh_reg from index 4 downward for the loopback check.
module tb_uart_tx;
    import uart_tx_pkg::*;

    localparam int BP      = 105;
    localparam int HALF    = 52;
    localparam int CHAR_T  = 1050;
    localparam int FRAME_T = 5250;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] par [0:4];
    logic       uart_data;
    logic       busy;
    logic       done;

    uart_tx dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .par       (par),
        .uart_data (uart_data),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Edge counter: after the k-th rising edge cyc equals k.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        int         t_start;
    } char_exp_t;

    char_exp_t  exp_q[$];
    int         done_q[$];
    int         n_cmp    = 0;
    int         n_err    = 0;
    int         done_cnt = 0;
    logic [7:0] sh_reg [0:4];
    int         rx_idx   = 4;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Serial monitor and receiver model.
    logic       in_char = 1'b0;
    int         t0      = 0;
    int         bit_j   = 0;
    logic [9:0] bits;
    char_exp_t  e;
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            in_char = 1'b0;
            rx_idx  = 4;
        end else if (!in_char) begin
            if (uart_data === 1'b0) begin
                in_char = 1'b1;
                t0      = cyc;
                bit_j   = 0;
            end
        end
        if (in_char && rst === 1'b0 && cyc == t0 + HALF + BP * bit_j) begin
            bits[bit_j] = uart_data;
            bit_j++;
            if (bit_j == 10) begin
                in_char = 1'b0;
                check("char_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("char_data", 32'(bits[8:1]), 32'(e.data));
                    check("char_start_cycle", t0, e.t_start);
                    check("char_start_bit", 32'(bits[0]), 32'd0);
                    check("char_stop_bit", 32'(bits[9]), 32'd1);
                end
                sh_reg[rx_idx] = bits[8:1];
                rx_idx = (rx_idx == 0) ? 4 : rx_idx - 1;
            end
        end
    end

    // Done-pulse monitor.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_cnt++;
            check("done_expected", 32'(done_q.size() != 0), 32'd1);
            if (done_q.size() != 0) begin
                check("done_cycle", cyc, done_q.pop_front());
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Expected frame accepted at edge n: characters par[4]..par[0].
    task automatic push_frame(input int n);
        for (int c = 0; c < 5; c++) begin
            exp_q.push_back('{data: par[4-c], t_start: n + CHAR_T * c});
        end
        done_q.push_back(n + FRAME_T);
    endtask

    task automatic send_frame(output int n);
        start = 1'b1;
        n = cyc + 1;
        push_frame(n);
        step(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int d0;
        int k;
        d0 = done_cnt;
        k  = 0;
        while (done_cnt == d0 && k < limit) begin
            step(1);
            k++;
        end
        check("done_within_budget", 32'(done_cnt != d0), 32'd1);
    endtask

    task automatic set_par(input logic [7:0] p4, input logic [7:0] p3, input logic [7:0] p2,
                           input logic [7:0] p1, input logic [7:0] p0);
        par[4] = p4; par[3] = p3; par[2] = p2; par[1] = p1; par[0] = p0;
    endtask

    logic [7:0] lb [0:4];
    int         n;
    int         n2;
    int         bad;

    // Directed stimulus.
    initial begin
        rst   = 1'b1;
        start = 1'b0;
        set_par(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        step(3);
        rst = 1'b0;

        // Reset state and quiet idle.
        check("rst_uart_data", 32'(uart_data), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        bad = 0;
        for (int i = 0; i < 500; i++) begin
            step(1);
            if (uart_data !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
        end
        check("idle_500_cycles_bad", bad, 32'd0);

        // Single frame.
        set_par(8'hA5, 8'h3C, 8'h00, 8'hFF, 8'h81);
        send_frame(n);
        check("accept_busy", 32'(busy), 32'd1);
        check("accept_start_bit", 32'(uart_data), 32'd0);
        wait_done(6000);
        step(20);

        // Busy gating and snapshot isolation.
        send_frame(n);
        step(300);
        start = 1'b1; step(1); start = 1'b0;
        step(700);
        set_par(8'h55, 8'h55, 8'h55, 8'h55, 8'h55);
        start = 1'b1; step(1); start = 1'b0;
        step(2000);
        start = 1'b1; step(1); start = 1'b0;
        wait_done(6000);
        step(300);
        check("snapshot_no_extra_busy", 32'(busy), 32'd0);
        check("snapshot_queue_drained", exp_q.size(), 32'd0);

        // Back-to-back: start held across the last busy edge and the done edge.
        set_par(8'h12, 8'h34, 8'h56, 8'h78, 8'h9A);
        send_frame(n);
        step(n + FRAME_T - 1 - cyc);
        check("b2b_busy_last_cycle", 32'(busy), 32'd1);
        start = 1'b1;
        step(1);
        check("b2b_done_pulse", 32'(done), 32'd1);
        check("b2b_busy_low", 32'(busy), 32'd0);
        set_par(8'hC3, 8'h0F, 8'hF0, 8'h01, 8'h80);
        n2 = n + FRAME_T + 1;
        push_frame(n2);
        step(1);
        start = 1'b0;
        check("b2b_restart_busy", 32'(busy), 32'd1);
        check("b2b_restart_start_bit", 32'(uart_data), 32'd0);
        check("b2b_done_single_cycle", 32'(done), 32'd0);
        wait_done(6000);
        step(20);

        // Mid-frame reset, then a clean frame.
        set_par(8'hA5, 8'h3C, 8'h00, 8'hFF, 8'h81);
        send_frame(n);
        step(n + 1999 - cyc);
        rst = 1'b1;
        exp_q.delete();
        done_q.delete();
        step(1);
        check("midrst_uart_data", 32'(uart_data), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        step(10);
        check("midrst_idle_line", 32'(uart_data), 32'd1);
        send_frame(n);
        wait_done(6000);
        step(20);

        // Loopback through the receiver model.
        lb[0] = 8'd10; lb[1] = 8'd20; lb[2] = 8'd30; lb[3] = 8'd40; lb[4] = 8'd50;
        set_par(lb[4], lb[3], lb[2], lb[1], lb[0]);
        send_frame(n);
        wait_done(6000);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("loopback_sh_reg_%0d", i), 32'(sh_reg[i]), 32'(lb[i]));
        end
        step(50);

        check("final_char_queue_empty", exp_q.size(), 32'd0);
        check("final_done_queue_empty", done_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global time bound.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded its time bound at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter for the controller's configuration link. It sends a frame of five 8-bit configuration parameters (ref_gen, phase_shift, ocd_lvl, inter_freq, inter_duty) over a single UART line as 8N1 characters, LSB first. It sits beside the UART receiver, uses the same bit timing and the same parameter ordering, and provides readback and loopback of the settings currently applied.

## Interface
- `BIT_CNT_MAX`, default 104: bit period is BIT_CNT_MAX+1 = 105 clk cycles, which matches the receiver.
- `DATA_BIT_CNT_MAX`, default 7: data bits per character minus one.
- `CONF_PAR_MAX`, default 255: maximum parameter value; the data width is `width(CONF_PAR_MAX)` = 8.
- `clk` input 1: the single clock; everything is on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request to send one frame; sampled only while `busy`=0.
- `par[0:CONF_PAR_4]` input 5×8: parameter array, indexed like the receiver's `sh_reg`.
- `uart_data` output 1: serial line; idles high.
- `busy` output 1: high from start acceptance until the frame ends.
- `done` output 1: one-cycle pulse when the frame ends.

## Operation
- Reset values: `uart_data`=1, `busy`=0, `done`=0, state TX_IDLE, counters cleared, snapshot cleared.
- **TX_IDLE**
  - If `start`=1, snapshot all of `par` and set the parameter index to CONF_PAR_4.
  - Go to TX_START and set `busy`=1.
  - The snapshot isolates the frame from `par` changes during transmission.
- **TX_START**
  - Drive `uart_data`=0 for one bit period, then go to TX_DATA with the bit index at 0.
- **TX_DATA**
  - Drive bit[index] of snap[par index], one bit period per bit, LSB first.
  - After bit DATA_BIT_CNT_MAX, go to TX_STOP.
- **TX_STOP**
  - Drive `uart_data`=1 for one bit period.
  - If par index ≠ 0: decrement it and go to TX_START. There is no extra idle gap between characters.
  - Else: go to TX_IDLE, set `busy`=0, and pulse `done`.
- Byte order on the wire is par[4], par[3], par[2], par[1], par[0]. The receiver fills `sh_reg` from index 4 downward, so a loopback reproduces the array exactly.
- Bit timer: loads BIT_CNT_MAX at the start of each bit and counts down to 0. At 0 it advances the bit or state and reloads.
- `start` while `busy`=1 is ignored. No queueing, no error flag.
- `rst` asserted mid-frame: the next cycle shows the reset values (line high, frame abandoned). The partial character is left for the receiver to discard.

## Timing
- `start` high at edge N with `busy`=0:
  - `busy`=1 and `uart_data`=0 from N+1.
  - The start bit occupies cycles N+1 to N+105.
- Data bit k (0-based) of character c (0-based) begins at N+1 + 105·(10c + 1 + k).
- Each character is 10 bit periods (1050 cycles). The full frame is 5250 cycles.
- The last stop bit ends at cycle N+5250.
  - At N+5251: `busy`=0 and `done`=1 for exactly one cycle.
  - A `start` sampled at N+5251 is accepted and the next start bit begins at N+5252.
- A `start` at N+5250 (still busy) is dropped.
- `uart_data` is a registered output with no combinational path from inputs.

## Structure
- Shared package (defines.sv / common package):
  - `Conf_par` enum and CONF_PAR_4.
  - New `Tx_state` enum { TX_IDLE, TX_START, TX_DATA, TX_STOP }.
  - Bit-period constant shared with the receiver, so both ends derive 105 from one place.
  - `reg`/`reg_2d`/`width` macros.
- One natural sub-module, `baud_timer`: a reloadable down-counter with `load` in and `tick` out (tick when the count is 0). It is reusable by the receiver later.
- Everything else is the FSM plus the snapshot array in uart_tx.

## Test plan
- **Reset:** hold `rst` 3 cycles, then release with `start`=0 → `uart_data`=1, `busy`=0, `done`=0 for 500 cycles.
- **Single frame:** par = {4:8'hA5, 3:8'h3C, 2:8'h00, 1:8'hFF, 0:8'h81}, `start` pulse at N.
  - Sample `uart_data` at bit centres → characters A5, 3C, 00, FF, 81, each LSB first with a 0 start bit and a 1 stop bit.
  - `done` only at N+5251.
- **Busy and snapshot:** repeat `start` pulses and change `par` to all 8'h55 mid-frame → exactly one frame, with the original bytes.
- **Back-to-back:** assert `start` in the `done` cycle → second start bit begins at N+5252, with no extra idle high.
- **Mid-frame reset:** `rst` at N+2000 → `uart_data`=1 and `busy`=0 from N+2001; a fresh `start` afterward sends a complete, correct frame.
- **Loopback:** connect `uart_data` to the receiver's `uart_data` and send values {10, 20, 30, 40, 50} → receiver `sh_reg[4..0]` equals `par[4..0]` after `done`.
